mac_seq_ctrl: RTL and testbench
===============================

Name: mac_seq_ctrl

Overview:
- Sequencer for the shared 4x4 multiply-accumulate datapath with a 12-bit accumulator.
- On a start command it clears the MAC, then accepts a fixed number of operand pairs over a valid/ready stream and issues one MAC enable per accepted pair.
- After the last pair it waits out the MAC latency, captures the accumulator and reports done.
- Sits between the operand source and the MAC top level, replacing the hand-driven go pulse used today.

Parameters:
- DW, 4, operand width (A and B).
- ACCW, 12, accumulator/result width.
- LEN_W, 4, width of the length field; maximum vector length is 2^LEN_W-1.
- MAC_LAT, 1, edges from an enable-high cycle to the accumulator reflecting that product (minimum 1).
- TIMEOUT, 16, idle-input cycle limit; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- len  in  LEN_W  number of operand pairs; latched when start is accepted.
- in_valid  in  1  operand pair available.
- in_a  in  DW  operand A.
- in_b  in  DW  operand B.
- in_ready  out  1  controller accepts a pair this cycle.
- mac_clr  out  1  accumulator clear to the MAC.
- mac_en  out  1  accumulate enable to the MAC.
- mac_a  out  DW  registered operand A to the MAC.
- mac_b  out  DW  registered operand B to the MAC.
- mac_acc  in  ACCW  accumulator value from the MAC.
- result  out  ACCW  captured dot-product.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset values: state IDLE; in_ready, mac_clr, mac_en, busy and done all 0; mac_a, mac_b and result all 0.
- Reset asserted mid-operation aborts immediately. No done is produced, result is cleared, and a partial MAC state is left as is; the next start clears it.
- Registered outputs: all outputs are registered except in_ready, which is combinational: in_ready = (state==RUN) && (remaining!=0).
- IDLE:
  - start=1 and len!=0: latch remaining=len, go to CLEAR.
  - start=1 and len==0: go to DONE with result=0; no mac_clr and no mac_en.
- CLEAR: mac_clr=1 for exactly this one cycle, then go to RUN.
- RUN:
  - Each edge with in_valid && in_ready registers in_a/in_b into mac_a/mac_b, sets mac_en=1 for the following cycle, and decrements remaining.
  - When in_valid=0, mac_en=0 for the following cycle and mac_a/mac_b hold their values.
  - The edge that accepts the last pair also moves to WAIT and loads wcnt=MAC_LAT.
- WAIT:
  - Decrements wcnt each cycle. The first WAIT cycle carries the final mac_en.
  - When wcnt reaches 0, capture result=mac_acc and go to DONE. Net effect: capture happens at edge E+1+MAC_LAT, where E is the last accepting edge.
- DONE: done=1 for one cycle, then go to IDLE. result holds until the next accepted start or reset.
- start while busy is ignored and has no side effects.
- len changes after start acceptance are ignored.
- Arithmetic width and overflow are owned by the MAC; result is mac_acc truncated to ACCW with no saturation.

Optional Feature:
- MAC_SEQ_CTRL_TIMEOUT_EN defined:
  - Adds output port err (1 bit, reset 0) and an idle counter that counts consecutive RUN cycles with in_valid=0.
  - The counter resets on every accepted pair.
  - On reaching TIMEOUT the controller goes to IDLE, pulses err for one cycle, does not pulse done, and leaves result unchanged.
- MAC_SEQ_CTRL_TIMEOUT_EN undefined:
  - No err port and no counter; RUN waits indefinitely for input.

Test Plan:
- Basic: start, len=3, pairs (1,3),(2,5),(3,7) streamed back-to-back with an ideal MAC model (MAC_LAT=1) -> mac_clr exactly once, 3 mac_en pulses, result=34, done one cycle at edge E+2, busy low after.
- Bubbles: len=4, pairs (15,15)x4 with in_valid low 2 cycles between pairs -> in_ready high throughout RUN, exactly 4 mac_en, result=900 (12-bit wrap rules checked against the model).
- Zero length: start with len=0 -> done within 2 cycles, result=0, no mac_clr or mac_en.
- Start while busy: second start, len=9, during RUN of len=2 (4,4),(5,5) -> ignored, result=41, exactly 2 mac_en.
- Reset mid-run: rst after 1 of 3 pairs -> all outputs return to reset values next cycle; a fresh len=1 (2,3) run gives result=6.
- Timeout (feature on, TIMEOUT=16): len=2, one pair, then in_valid low -> err pulses on the 16th idle cycle, no done, result unchanged, busy=0.

Source files
------------

// File: rtl/mac_seq_ctrl_if.sv
// Operand stream, MAC control and status bundle for the MAC sequencer.
// MAC_SEQ_CTRL_TIMEOUT_EN adds the err status line.
interface mac_seq_ctrl_if #(
    parameter int DW    = 4,
    parameter int ACCW  = 12,
    parameter int LEN_W = 4
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic [DW-1:0]    in_a;
    logic [DW-1:0]    in_b;
    logic             in_ready;
    logic             mac_clr;
    logic             mac_en;
    logic [DW-1:0]    mac_a;
    logic [DW-1:0]    mac_b;
    logic [ACCW-1:0]  mac_acc;
    logic [ACCW-1:0]  result;
    logic             busy;
    logic             done;
`ifdef MAC_SEQ_CTRL_TIMEOUT_EN
    logic             err;
`endif

    modport slave (
        input  start, len, in_valid, in_a, in_b, mac_acc,
`ifdef MAC_SEQ_CTRL_TIMEOUT_EN
        output err,
`endif
        output in_ready, mac_clr, mac_en, mac_a, mac_b, result, busy, done
    );

    modport master (
        output start, len, in_valid, in_a, in_b, mac_acc,
`ifdef MAC_SEQ_CTRL_TIMEOUT_EN
        input  err,
`endif
        input  in_ready, mac_clr, mac_en, mac_a, mac_b, result, busy, done
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Sequencer for the 4x4 MAC: clear, stream len operand pairs, wait out MAC latency, capture result.
// Optional input-starvation timeout with err pulse when MAC_SEQ_CTRL_TIMEOUT_EN is defined.
module mac_seq_ctrl #(
    parameter int DW      = 4,
    parameter int ACCW    = 12,
    parameter int LEN_W   = 4,
    parameter int MAC_LAT = 1,
    parameter int TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst,
    mac_seq_ctrl_if.slave  bus
);
    localparam int WCW = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, WAIT, DONE} state_t;

    state_t           state_reg, state_next;
    logic [LEN_W-1:0] remaining_reg, remaining_next;
    logic [WCW-1:0]   wcnt_reg, wcnt_next;
    logic [DW-1:0]    mac_a_reg, mac_a_next;
    logic [DW-1:0]    mac_b_reg, mac_b_next;
    logic [ACCW-1:0]  result_reg, result_next;
    logic             mac_en_reg, mac_en_next;
    logic             mac_clr_reg, mac_clr_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             in_ready;
    logic             accept;
    logic             starved;

`ifdef MAC_SEQ_CTRL_TIMEOUT_EN
    localparam int ICW = $clog2(TIMEOUT + 1);
    logic [ICW-1:0]   idle_cnt_reg, idle_cnt_next;
    logic             err_reg, err_next;

    // Fires on the TIMEOUT-th consecutive RUN cycle without input.
    assign starved = (state_reg == RUN) && !bus.in_valid && (idle_cnt_reg == ICW'(TIMEOUT - 1));
`else
    assign starved = 1'b0;
`endif

    assign in_ready = (state_reg == RUN) && (remaining_reg != '0);
    assign accept   = bus.in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            wcnt_reg      <= '0;
            mac_a_reg     <= '0;
            mac_b_reg     <= '0;
            result_reg    <= '0;
            mac_en_reg    <= 1'b0;
            mac_clr_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            wcnt_reg      <= wcnt_next;
            mac_a_reg     <= mac_a_next;
            mac_b_reg     <= mac_b_next;
            result_reg    <= result_next;
            mac_en_reg    <= mac_en_next;
            mac_clr_reg   <= mac_clr_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

`ifdef MAC_SEQ_CTRL_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            idle_cnt_reg <= idle_cnt_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        idle_cnt_next = '0;
        err_next      = starved;
        if (state_reg == RUN && !bus.in_valid && !starved)
            idle_cnt_next = idle_cnt_reg + 1'b1;
    end

    assign bus.err = err_reg;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (bus.start) state_next = (bus.len != '0) ? CLEAR : DONE;
            CLEAR: state_next = RUN;
            RUN: begin
                if (accept && remaining_reg == LEN_W'(1)) state_next = WAIT;
                else if (starved)                         state_next = IDLE;
            end
            WAIT:  if (wcnt_reg == '0) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values for every registered output and counter.
    always_comb begin
        remaining_next = remaining_reg;
        wcnt_next      = wcnt_reg;
        mac_a_next     = mac_a_reg;
        mac_b_next     = mac_b_reg;
        result_next    = result_reg;
        mac_en_next    = 1'b0;
        mac_clr_next   = (state_next == CLEAR);
        busy_next      = (state_next != IDLE);
        done_next      = (state_next == DONE);
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    remaining_next = bus.len;
                    result_next    = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    mac_a_next     = bus.in_a;
                    mac_b_next     = bus.in_b;
                    mac_en_next    = 1'b1;
                    remaining_next = remaining_reg - 1'b1;
                    wcnt_next      = WCW'(MAC_LAT);
                end
            end
            WAIT: begin
                if (wcnt_reg == '0) result_next = bus.mac_acc;
                else                wcnt_next   = wcnt_reg - 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.in_ready = in_ready;
    assign bus.mac_clr  = mac_clr_reg;
    assign bus.mac_en   = mac_en_reg;
    assign bus.mac_a    = mac_a_reg;
    assign bus.mac_b    = mac_b_reg;
    assign bus.result   = result_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed-vector bench for mac_seq_ctrl with a one-cycle-latency ideal MAC alongside.
// Define MAC_SEQ_CTRL_TIMEOUT_EN to also exercise the timeout path.
module tb_mac_seq_ctrl;
    localparam int DW = 4, ACCW = 12, LEN_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mac_seq_ctrl_if #(.DW(DW), .ACCW(ACCW), .LEN_W(LEN_W)) bus ();

    mac_seq_ctrl #(.DW(DW), .ACCW(ACCW), .LEN_W(LEN_W), .MAC_LAT(1), .TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Ideal MAC: product lands in the accumulator one edge after the enable cycle.
    logic [ACCW-1:0] acc_model = '0;
    always_ff @(posedge clk) begin
        if (bus.mac_clr)     acc_model <= '0;
        else if (bus.mac_en) acc_model <= acc_model + ACCW'(bus.mac_a) * ACCW'(bus.mac_b);
    end
    assign bus.mac_acc = acc_model;

    int tests = 0, fails = 0;
    int cyc = 0, en_cnt = 0, clr_cnt = 0, last_acc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus.mac_en)  en_cnt  = en_cnt + 1;
        if (bus.mac_clr) clr_cnt = clr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_start(input int l);
        bus.start = 1'b1;
        bus.len   = LEN_W'(l);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send_pair(input int a, input int b, input int gap, input bit chk_rdy);
        int n = 0;
        bus.in_a     = DW'(a);
        bus.in_b     = DW'(b);
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", 32'(n < 50), 1);
        last_acc = cyc + 1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < gap; i++) begin
            if (chk_rdy) chk("bubble_ready", 32'(bus.in_ready), 1);
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input string tag, output int done_edge);
        int n = 0;
        while (!bus.done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, 32'(bus.done), 1);
        done_edge = cyc;
        $display("[TB] run %s: result=%0d at edge %0d", tag, bus.result, done_edge);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 0);
        chk({tag, "_mac_clr"},  32'(bus.mac_clr), 0);
        chk({tag, "_mac_en"},   32'(bus.mac_en), 0);
        chk({tag, "_mac_a"},    32'(bus.mac_a), 0);
        chk({tag, "_mac_b"},    32'(bus.mac_b), 0);
        chk({tag, "_result"},   32'(bus.result), 0);
        chk({tag, "_busy"},     32'(bus.busy), 0);
        chk({tag, "_done"},     32'(bus.done), 0);
`ifdef MAC_SEQ_CTRL_TIMEOUT_EN
        chk({tag, "_err"},      32'(bus.err), 0);
`endif
    endtask

    initial begin
        int c0, e0, de, se;
        bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
        repeat (3) @(negedge clk);
        chk_reset_state("rst");
        rst = 1'b0;
        @(negedge clk);

        // Basic: 1*3 + 2*5 + 3*7 = 34
        c0 = clr_cnt; e0 = en_cnt;
        do_start(3);
        send_pair(1, 3, 0, 0); send_pair(2, 5, 0, 0); send_pair(3, 7, 0, 0);
        wait_done("basic", de);
        chk("basic_latency", 32'(de - last_acc), 2);
        chk("basic_result", 32'(bus.result), 34);
        @(negedge clk);
        chk("basic_done_pulse", 32'(bus.done), 0);
        chk("basic_busy_after", 32'(bus.busy), 0);
        chk("basic_clr_count", 32'(clr_cnt - c0), 1);
        chk("basic_en_count", 32'(en_cnt - e0), 3);

        // Bubbles: 4 * 225 = 900
        c0 = clr_cnt; e0 = en_cnt;
        do_start(4);
        for (int i = 0; i < 4; i++) send_pair(15, 15, (i < 3) ? 2 : 0, i < 3);
        wait_done("bubbles", de);
        chk("bubbles_result", 32'(bus.result), 900);
        @(negedge clk);
        chk("bubbles_en_count", 32'(en_cnt - e0), 4);
        chk("bubbles_clr_count", 32'(clr_cnt - c0), 1);

        // Zero length
        c0 = clr_cnt; e0 = en_cnt;
        se = cyc + 1;
        do_start(0);
        wait_done("zero_len", de);
        chk("zero_len_latency_ok", 32'((de - se) <= 1), 1);
        chk("zero_len_result", 32'(bus.result), 0);
        @(negedge clk);
        chk("zero_len_busy_after", 32'(bus.busy), 0);
        chk("zero_len_clr_count", 32'(clr_cnt - c0), 0);
        chk("zero_len_en_count", 32'(en_cnt - e0), 0);

        // Start while busy: 16 + 25 = 41
        c0 = clr_cnt; e0 = en_cnt;
        do_start(2);
        send_pair(4, 4, 0, 0);
        do_start(9);
        send_pair(5, 5, 0, 0);
        wait_done("busy_start", de);
        chk("busy_start_result", 32'(bus.result), 41);
        @(negedge clk);
        @(negedge clk);
        chk("busy_start_idle_after", 32'(bus.busy), 0);
        chk("busy_start_en_count", 32'(en_cnt - e0), 2);
        chk("busy_start_clr_count", 32'(clr_cnt - c0), 1);

        // Reset mid-run, then a fresh 2*3 run
        do_start(3);
        send_pair(1, 1, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_state("midrst");
        rst = 1'b0;
        @(negedge clk);
        do_start(1);
        send_pair(2, 3, 0, 0);
        wait_done("after_rst", de);
        chk("after_rst_result", 32'(bus.result), 6);
        @(negedge clk);

`ifdef MAC_SEQ_CTRL_TIMEOUT_EN
        begin
            int n, r0;
            bit saw_done;
            n = 0; saw_done = 1'b0;
            do_start(2);
            send_pair(7, 7, 0, 0);
            r0 = 32'(bus.result);
            while (!bus.err && n < 40) begin
                if (bus.done) saw_done = 1'b1;
                @(negedge clk);
                n++;
            end
            $display("[TB] run timeout: err at edge %0d", cyc);
            chk("timeout_err_seen", 32'(bus.err), 1);
            chk("timeout_latency", 32'(cyc - last_acc), 16);
            chk("timeout_no_done", 32'(saw_done), 0);
            chk("timeout_result_kept", 32'(bus.result), 32'(r0));
            chk("timeout_busy", 32'(bus.busy), 0);
            @(negedge clk);
            chk("timeout_err_pulse", 32'(bus.err), 0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
